dmem_bridge: RTL and testbench



---
 rtl/dmem_bridge_pkg.sv | 15 +
 rtl/dmem_ldext.sv | 26 ++
 rtl/dmem_bridge.sv | 156 +++++++++++++++
 tb/tb_dmem_bridge.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared encodings for the memory-stage bridge: FSM states and bus size codes.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/dmem_ldext.sv
// Combinational load align/extend: moves the addressed byte/half into the low
// bits and sign- or zero-extends it; word loads pass through.
module dmem_ldext
  import dmem_bridge_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SIZE_B:  data_o = {{24{sign_i & shifted[7]}}, shifted[7:0]};
      SIZE_H:  data_o = {{16{sign_i & shifted[15]}}, shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage to data-SRAM bus bridge: one bus transaction per memory instruction,
// pipeline stalled until data_ok. Define DMEM_LOAD_EXT_EN to align/extend loads here.
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        memenM,
  input  logic [3:0]  memwriteM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  input  logic [1:0]  ldsizeM,
  input  logic        ldsignM,
  input  logic        flushM,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        stallM,
  output logic [31:0] rdataM
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        wr_q, wr_d;
  logic        ldsign_q, ldsign_d;
  logic        cancel_q, cancel_d;
  logic        start;
  logic        st_wr;
  logic [1:0]  st_sz;
  logic [31:0] ld_word;

  function automatic logic [1:0] store_size(input logic [3:0] be);
    case (be)
      4'b1111:         store_size = SIZE_W;
      4'b0011, 4'b1100: store_size = SIZE_H;
      default:         store_size = SIZE_B;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SIZE_B:  store_lanes = {4{d[7:0]}};
      SIZE_H:  store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  assign start = memenM && !flushM;
  assign st_wr = |memwriteM;
  assign st_sz = store_size(memwriteM);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    wr_d     = wr_q;
    ldsign_d = ldsign_q;
    cancel_d = cancel_q;
    stallM   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stallM   = 1'b1;
          state_d  = REQ;
          addr_d   = addrM;
          wr_d     = st_wr;
          size_d   = st_wr ? st_sz : ldsizeM;
          wdata_d  = store_lanes(st_sz, wdataM);
          ldsign_d = ldsignM;
        end
      end
      REQ: begin
        stallM = 1'b1;
        if (flushM) cancel_d = 1'b1;
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) begin
            state_d = DONE;
            rdata_d = data_sram_rdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stallM = 1'b1;
        if (flushM) cancel_d = 1'b1;
        if (data_sram_data_ok) begin
          state_d = DONE;
          rdata_d = data_sram_rdata;
        end
      end
      DONE: begin
        // The pipeline advances this cycle, so return to IDLE without re-issuing.
        state_d  = IDLE;
        cancel_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      ldsign_q <= 1'b0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      wr_q     <= wr_d;
      ldsign_q <= ldsign_d;
      cancel_q <= cancel_d;
    end
  end

  assign data_sram_req   = (state_q == REQ);
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;

`ifdef DMEM_LOAD_EXT_EN
  dmem_ldext u_ldext (
    .rdata_i   (rdata_q),
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .sign_i    (ldsign_q),
    .data_o    (ld_word)
  );
`else
  logic unused_ldsign;
  assign unused_ldsign = ldsign_q;
  assign ld_word       = rdata_q;
`endif

  // A flushed transaction still completes on the bus but returns nothing.
  assign rdataM = (state_q == DONE && !cancel_q) ? ld_word : '0;

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: load results are queued at issue and
// compared in the DONE cycle; bus fields and stall are checked every cycle.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM;
  logic [3:0]  memwriteM;
  logic [31:0] addrM, wdataM;
  logic [1:0]  ldsizeM;
  logic        ldsignM, flushM;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] baddr, bwdata;
  logic        addr_ok, data_ok;
  logic [31:0] brdata;
  logic        stallM;
  logic [31:0] rdataM;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  dmem_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .memenM            (memenM),
    .memwriteM         (memwriteM),
    .addrM             (addrM),
    .wdataM            (wdataM),
    .ldsizeM           (ldsizeM),
    .ldsignM           (ldsignM),
    .flushM            (flushM),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (baddr),
    .data_sram_wdata   (bwdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (brdata),
    .stallM            (stallM),
    .rdataM            (rdataM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] a,
                                           input logic [1:0] sz, input logic sg);
`ifdef DMEM_LOAD_EXT_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    if (sz == 2'd0)      exp_load = sg ? {{24{b[7]}}, b} : {24'h0, b};
    else if (sz == 2'd1) exp_load = sg ? {{16{h[15]}}, h} : {16'h0, h};
    else                 exp_load = rd;
`else
    exp_load = rd;
`endif
  endfunction

  // One memory instruction: k=0 is the IDLE issue cycle, k=1 the first REQ cycle.
  task automatic run_txn(input logic [3:0] mw, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] lsz, input logic lsg, input int aok, input int dok,
                         input logic [31:0] bus_rd, input logic fl,
                         input logic [1:0] esz, input logic [31:0] ewd);
    int   done_k;
    logic is_ld;
    logic [31:0] e;
    done_k = aok + dok + 2;
    is_ld  = (mw == 4'b0000);
    if (is_ld) sb_q.push_back(fl ? 32'h0 : exp_load(bus_rd, a[1:0], lsz, lsg));
    for (int k = 0; k <= done_k + 1; k++) begin
      @(posedge clk); #1;
      memenM    = (k <= done_k);
      memwriteM = mw;
      addrM     = a;
      wdataM    = wd;
      ldsizeM   = lsz;
      ldsignM   = lsg;
      flushM    = fl && (k == 2 + aok);
      addr_ok   = (k == 1 + aok);
      data_ok   = (k == 1 + aok + dok);
      brdata    = (k == 1 + aok + dok) ? bus_rd : 32'hDEAD_BEEF;
      @(negedge clk);
      chk("stall", 32'(stallM), 32'(k < done_k));
      chk("req", 32'(req), 32'(k >= 1 && k <= 1 + aok));
      if (k >= 1 && k <= 1 + aok) begin
        chk("addr", baddr, a);
        chk("wr", 32'(wr), 32'(!is_ld));
        chk("size", 32'(size), 32'(esz));
        if (!is_ld) chk("wdata", bwdata, ewd);
      end
      if (k == done_k && is_ld) begin
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sb_q.pop_front();
          chk("rdataM", rdataM, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; memenM = 0; memwriteM = 0; addrM = 0; wdataM = 0;
    ldsizeM = 0; ldsignM = 0; flushM = 0; addr_ok = 0; data_ok = 0; brdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(req), 0);
    chk("rst_stall", 32'(stallM), 0);
    chk("rst_rdata", rdataM, 0);
    chk("rst_addr", baddr, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_txn(4'b1111, 32'h100, 32'h1234_5678, 2'd0, 1'b0, 0, 0, 32'h0, 1'b0, 2'd2, 32'h1234_5678);
    run_txn(4'b1000, 32'h103, 32'h0000_00AB, 2'd0, 1'b0, 0, 0, 32'h0, 1'b0, 2'd0, 32'hABAB_ABAB);
    run_txn(4'b1100, 32'h102, 32'h0000_BEEF, 2'd0, 1'b0, 1, 1, 32'h0, 1'b0, 2'd1, 32'hBEEF_BEEF);
    run_txn(4'b0000, 32'h102, 32'h0, 2'd0, 1'b1, 0, 1, 32'h0080_FF00, 1'b0, 2'd0, 32'h0);
    run_txn(4'b0000, 32'h100, 32'h0, 2'd1, 1'b0, 3, 2, 32'hBEEF_8001, 1'b0, 2'd1, 32'h0);
    run_txn(4'b0000, 32'h102, 32'h0, 2'd1, 1'b1, 1, 0, 32'h8001_1234, 1'b0, 2'd1, 32'h0);
    run_txn(4'b0000, 32'h104, 32'h0, 2'd2, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0, 2'd2, 32'h0);
    run_txn(4'b0000, 32'h101, 32'h0, 2'd0, 1'b0, 0, 0, 32'h0000_8000, 1'b0, 2'd0, 32'h0);
    run_txn(4'b0000, 32'h108, 32'h0, 2'd2, 1'b0, 1, 3, 32'h1357_9BDF, 1'b1, 2'd2, 32'h0);

    // Flushed in IDLE: no transaction starts; stray data_ok is ignored.
    @(posedge clk); #1 memenM = 1; memwriteM = 0; flushM = 1; data_ok = 1; addr_ok = 0;
    @(negedge clk);
    chk("flush_idle_stall", 32'(stallM), 0);
    @(posedge clk); #1 memenM = 0; flushM = 0; data_ok = 1;
    @(negedge clk);
    chk("flush_idle_req", 32'(req), 0);
    chk("stray_dok_rdata", rdataM, 0);
    @(posedge clk); #1 data_ok = 0;

    // Reset in WAIT aborts asynchronously.
    @(posedge clk); #1 memenM = 1; memwriteM = 0; addrM = 32'h200; wdataM = 32'h5555_AAAA;
    ldsizeM = 2'd2; ldsignM = 0; addr_ok = 0; data_ok = 0;
    @(posedge clk); #1 addr_ok = 1;
    @(posedge clk); #1 addr_ok = 0;
    @(negedge clk);
    chk("wait_stall", 32'(stallM), 1);
    chk("wait_addr", baddr, 32'h200);
    #1 rst = 1'b1; memenM = 0;
    #1;
    chk("arst_req", 32'(req), 0);
    chk("arst_wr", 32'(wr), 0);
    chk("arst_size", 32'(size), 0);
    chk("arst_addr", baddr, 0);
    chk("arst_wdata", bwdata, 0);
    chk("arst_stall", 32'(stallM), 0);
    chk("arst_rdata", rdataM, 0);
    @(posedge clk); #1 rst = 1'b0;

    run_txn(4'b0000, 32'h204, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0BAD_F00D, 1'b0, 2'd2, 32'h0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
